uart_tx_sched: RTL
==================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the transmitter (2..8).
REQ-002 Parameter START_TMO, default 16, clk16 cycles allowed between tx_start and the first tx_busy high.
REQ-003 clk16  in  1  sole clock; all flops on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req  in  NREQ  per-requester level request; held high with its byte until that requester's ack.
REQ-006 req_data  in  8*NREQ  byte for requester n at bits [8n+7:8n].
REQ-007 ack  out  NREQ  one-cycle pulse: byte of requester n captured.
REQ-008 done  out  NREQ  one-cycle pulse: frame of requester n finished on the line.
REQ-009 tx_data  out  8  byte presented to the transmitter; stable from tx_start until return to IDLE.
REQ-010 tx_start  out  1  one-cycle pulse launching a frame.
REQ-011 tx_busy  in  1  transmitter frame-in-progress flag, synchronous to clk16.
REQ-012 tmo_err  out  1  one-cycle pulse: transmitter failed to go busy within START_TMO.
REQ-013 sched_idle  out  1  high only in state IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, WAIT_BUSY, SEND.
REQ-015 IDLE: if any req bit is high, the winner SHALL be chosen round-robin, searching from last_grant+1 modulo NREQ, and the FSM SHALL go to LOAD next cycle; otherwise it SHALL stay in IDLE.
REQ-016 LOAD (exactly one cycle): tx_data SHALL take the winner's byte, tx_start and ack[winner] SHALL pulse together, and the FSM SHALL go to WAIT_BUSY.
REQ-017 WAIT_BUSY: tx_busy high SHALL move the FSM to SEND; after START_TMO cycles without tx_busy, tmo_err SHALL pulse, last_grant SHALL update to the winner, and the FSM SHALL return to IDLE with no done pulse.
REQ-018 SEND: on the first cycle tx_busy is low, done[winner] SHALL pulse, last_grant SHALL update to the winner, and the FSM SHALL return to IDLE.
REQ-019 Latency SHALL be req edge to tx_start = 2 cycles when idle; done to the next tx_start = 2 cycles minimum.
REQ-020 A req deasserted before its ack SHALL be dropped without a pulse; req changes after ack SHALL NOT affect the frame in flight.
REQ-021 At most one bit of ack, and at most one bit of done, SHALL be high in any cycle.
REQ-022 Timeout counter width SHALL be $clog2(START_TMO+1); it SHALL clear on entry to WAIT_BUSY and SHALL NOT wrap.
REQ-023 Winner index SHALL wrap from NREQ-1 to 0.

Reset
REQ-024 On rst: FSM=IDLE, last_grant=NREQ-1 (requester 0 wins first), tx_data=0, tx_start=0, ack=0, done=0, tmo_err=0, sched_idle=1.
REQ-025 Reset asserted mid-frame SHALL abort to IDLE next cycle with no done or tmo_err pulse.

Configuration
REQ-026 Macro UART_TX_SCHED_PRIO_EN: when defined, requester 0 SHALL win whenever its req is high in IDLE, and round-robin SHALL apply only among the others; when undefined, all requesters SHALL be pure round-robin.

Structure
REQ-027 Package uart_pkg SHALL hold the FSM state enum, the default NREQ and START_TMO constants, and the byte-width constant 8.
REQ-028 The round-robin search SHALL be one sub-module, rr_arbiter (inputs req and last_grant; outputs grant index and any_req), purely combinational.

Verification
REQ-029 Single request: req=4'b0100, byte 0xA5; tx_busy high 3 cycles after start for 10 cycles -> tx_start at cycle 2, tx_data=0xA5, ack=4'b0100, done=4'b0100 when busy falls.
REQ-030 All four requesting continuously -> grant order 0,1,2,3,0; each done precedes the next tx_start.
REQ-031 tx_busy never asserted -> tmo_err pulses 16 cycles after tx_start, no done, next requester is served.
REQ-032 rst asserted during SEND -> next cycle sched_idle=1, all outputs at reset values, requester 0 is the next winner.
REQ-033 With UART_TX_SCHED_PRIO_EN defined, req=4'b1111 held -> order 0,0,0...; with req0 dropped after its first ack -> order 0,1,2,3.
REQ-034 req[1] pulsed for one cycle while the FSM is in SEND -> no ack[1] and no frame for requester 1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the UART transmit scheduler.
// Optional build macro consumed elsewhere: UART_TX_SCHED_PRIO_EN.
package uart_pkg;

    localparam int BYTE_W        = 8;
    localparam int DEF_NREQ      = 4;
    localparam int DEF_START_TMO = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_SEND      = 2'd3
    } state_t;

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin search starting at last_grant+1, wrapping NREQ-1 -> 0.
// UART_TX_SCHED_PRIO_EN: requester 0 wins outright; round-robin covers the rest.
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic [IW-1:0]   grant,
    output logic            any_req
);

    logic          found;
    logic [IW-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = IW'((int'(last_grant) + i) % NREQ);
`ifdef UART_TX_SCHED_PRIO_EN
            if (!found && req[idx] && (idx != '0)) begin
`else
            if (!found && req[idx]) begin
`endif
                grant = idx;
                found = 1'b1;
            end
        end
`ifdef UART_TX_SCHED_PRIO_EN
        if (req[0]) begin
            grant = '0;
        end
`endif
    end

    assign any_req = |req;

endmodule

// File: rtl/uart_tx_sched.sv
// Arbitrates NREQ byte requesters onto one UART transmitter: IDLE -> LOAD -> WAIT_BUSY -> SEND.
// Build macro UART_TX_SCHED_PRIO_EN gives requester 0 absolute priority.
module uart_tx_sched
    import uart_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int START_TMO = DEF_START_TMO,
    localparam int IW       = $clog2(NREQ),
    localparam int CW       = $clog2(START_TMO + 1)
) (
    input  logic                   clk16,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [BYTE_W*NREQ-1:0] req_data,
    output logic [NREQ-1:0]        ack,
    output logic [NREQ-1:0]        done,
    output logic [BYTE_W-1:0]      tx_data,
    output logic                   tx_start,
    input  logic                   tx_busy,
    output logic                   tmo_err,
    output logic                   sched_idle
);

    state_t              state_q, state_d;
    logic [IW-1:0]       last_grant_q, last_grant_d;
    logic [IW-1:0]       winner_q, winner_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BYTE_W-1:0]   tx_data_q, tx_data_d;
    logic                tx_start_q, tx_start_d;
    logic [NREQ-1:0]     ack_q, ack_d;
    logic [NREQ-1:0]     done_q, done_d;
    logic                tmo_q, tmo_d;
    logic [IW-1:0]       grant;
    logic                any_req;
    logic [NREQ-1:0]     winner_oh;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req        (req),
        .last_grant (last_grant_q),
        .grant      (grant),
        .any_req    (any_req)
    );

    assign winner_oh = {{(NREQ-1){1'b0}}, 1'b1} << winner_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        winner_d     = winner_q;
        cnt_d        = cnt_q;
        tx_data_d    = tx_data_q;
        tx_start_d   = 1'b0;
        ack_d        = '0;
        done_d       = '0;
        tmo_d        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    winner_d = grant;
                    state_d  = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // A requester that let go before being acknowledged is silently dropped.
                if (req[winner_q]) begin
                    tx_data_d  = req_data[BYTE_W*winner_q +: BYTE_W];
                    tx_start_d = 1'b1;
                    ack_d      = winner_oh;
                    cnt_d      = '0;
                    state_d    = ST_WAIT_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = ST_SEND;
                end else if (cnt_q == CW'(START_TMO - 1)) begin
                    tmo_d        = 1'b1;
                    last_grant_d = winner_q;
                    state_d      = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_SEND: begin
                if (!tx_busy) begin
                    done_d       = winner_oh;
                    last_grant_d = winner_q;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk16) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IW'(NREQ - 1);
            winner_q     <= '0;
            cnt_q        <= '0;
            tx_data_q    <= '0;
            tx_start_q   <= 1'b0;
            ack_q        <= '0;
            done_q       <= '0;
            tmo_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            winner_q     <= winner_d;
            cnt_q        <= cnt_d;
            tx_data_q    <= tx_data_d;
            tx_start_q   <= tx_start_d;
            ack_q        <= ack_d;
            done_q       <= done_d;
            tmo_q        <= tmo_d;
        end
    end

    assign ack        = ack_q;
    assign done       = done_q;
    assign tx_data    = tx_data_q;
    assign tx_start   = tx_start_q;
    assign tmo_err    = tmo_q;
    assign sched_idle = (state_q == ST_IDLE);

endmodule
